// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding-select encodings and mult/div tracker state encoding
// shared by hazard_unit and md_busy_tracker.
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/hazard_unit_md_busy_tracker.sv
// md_busy_tracker: holds md_busy high for MD_LATENCY cycles after a mult/div launch
// is sampled in E; a launch while already busy is ignored.
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start_e,
    output logic md_busy
);

    localparam int CW = $clog2(MD_LATENCY + 1);

    md_state_e         r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == MD_IDLE) begin
            if (md_start_e) begin
                w_state_nxt = MD_BUSY;
                w_cnt_nxt   = CW'(MD_LATENCY - 1);
            end
        end else begin
            w_state_nxt = (r_cnt == '0) ? MD_IDLE : MD_BUSY;
            w_cnt_nxt   = (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
        end
    end

    assign md_busy = (r_state == MD_BUSY);

    // md_stall upstream should make this unreachable
    a_no_start_while_busy : assert property (
        @(posedge clk) disable iff (!rst_n) !(md_start_e && r_state == MD_BUSY));

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: EX/D operand forwarding, load-use/branch/mult-div stall detection.
// HAZ_PERF_CNT_EN enables saturating stall/forward performance counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MD_LATENCY = 32,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] write_reg_e,
    input  logic [REG_AW-1:0] write_reg_m,
    input  logic [REG_AW-1:0] write_reg_w,
    input  logic              reg_write_e,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic              mem_to_reg_e,
    input  logic              mem_to_reg_m,
    input  logic              branch_d,
    input  logic              md_use_d,
    input  logic              md_start_e,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              forward_a_d,
    output logic              forward_b_d,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_e,
    output logic              md_busy,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_fwd_cnt
);

    logic w_a_m, w_a_w, w_b_m, w_b_w;
    logic w_dep_e, w_dep_m, w_lw_stall, w_br_stall, w_md_stall, w_stall, w_any_fwd;

    assign w_a_m = (rs_e != '0) && (rs_e == write_reg_m) && reg_write_m;
    assign w_a_w = (rs_e != '0) && (rs_e == write_reg_w) && reg_write_w;
    assign w_b_m = (rt_e != '0) && (rt_e == write_reg_m) && reg_write_m;
    assign w_b_w = (rt_e != '0) && (rt_e == write_reg_w) && reg_write_w;

    assign forward_a_e = w_a_m ? FWD_MEM : w_a_w ? FWD_WB : FWD_REG;
    assign forward_b_e = w_b_m ? FWD_MEM : w_b_w ? FWD_WB : FWD_REG;
    assign forward_a_d = (rs_d != '0) && (rs_d == write_reg_m) && reg_write_m;
    assign forward_b_d = (rt_d != '0) && (rt_d == write_reg_m) && reg_write_m;

    assign w_dep_e    = (write_reg_e != '0) && (write_reg_e == rs_d || write_reg_e == rt_d);
    assign w_dep_m    = (write_reg_m != '0) && (write_reg_m == rs_d || write_reg_m == rt_d);
    assign w_lw_stall = mem_to_reg_e && w_dep_e;
    assign w_br_stall = branch_d && ((reg_write_e && w_dep_e) || (mem_to_reg_m && w_dep_m));
    assign w_md_stall = md_use_d && (md_busy || md_start_e);
    assign w_stall    = w_lw_stall | w_br_stall | w_md_stall;

    assign stall_f = w_stall;
    assign stall_d = w_stall;
    assign flush_e = w_stall;

    assign w_any_fwd = (forward_a_e != FWD_REG) || (forward_b_e != FWD_REG) ||
                       forward_a_d || forward_b_d;

    md_busy_tracker #(.MD_LATENCY(MD_LATENCY)) u_md (
        .clk        (clk),
        .rst_n      (rst_n),
        .md_start_e (md_start_e),
        .md_busy    (md_busy)
    );

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] r_perf_stall, r_perf_fwd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
            r_perf_fwd   <= '0;
        end else begin
            if (w_stall && !(&r_perf_stall))  r_perf_stall <= r_perf_stall + 1'b1;
            if (w_any_fwd && !(&r_perf_fwd))  r_perf_fwd   <= r_perf_fwd + 1'b1;
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_fwd_cnt   = r_perf_fwd;
`else
    logic w_unused_perf;
    assign w_unused_perf  = w_any_fwd;
    assign perf_stall_cnt = '0;
    assign perf_fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors for hazard_unit (MD_LATENCY=4, PERF_W=4);
// perf expectations follow HAZ_PERF_CNT_EN.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
    logic       reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
    logic       branch_d, md_use_d, md_start_e;
    logic [1:0] forward_a_e, forward_b_e;
    logic       forward_a_d, forward_b_d, stall_f, stall_d, flush_e, md_busy;
    logic [3:0] perf_stall_cnt, perf_fwd_cnt;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef HAZ_PERF_CNT_EN
    localparam logic [3:0] PERF_SAT = 4'd15;
    localparam logic [3:0] PERF_5   = 4'd5;
`else
    localparam logic [3:0] PERF_SAT = 4'd0;
    localparam logic [3:0] PERF_5   = 4'd0;
`endif

    always #5 clk = ~clk;

    hazard_unit #(.REG_AW(5), .MD_LATENCY(4), .PERF_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
        .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
        .branch_d(branch_d), .md_use_d(md_use_d), .md_start_e(md_start_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e), .md_busy(md_busy),
        .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_inputs();
        {rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w} = '0;
        {reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m} = '0;
        {branch_d, md_use_d, md_start_e} = '0;
    endtask

    task automatic check_stall(input string tag, input logic exp);
        check({tag, "_stall_f"}, 32'(stall_f), 32'(exp));
        check({tag, "_stall_d"}, 32'(stall_d), 32'(exp));
        check({tag, "_flush_e"}, 32'(flush_e), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #3;
        check("rst_md_busy", 32'(md_busy), 0);
        check_stall("rst", 1'b0);
        check("rst_fa_e", 32'(forward_a_e), 0);
        check("rst_perf_stall", 32'(perf_stall_cnt), 0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // EX forwarding priority
        rs_e = 5'd3; write_reg_m = 5'd3; reg_write_m = 1'b1; write_reg_w = 5'd3; reg_write_w = 1'b1;
        #1 check("fa_e_mem", 32'(forward_a_e), 32'h2);
        reg_write_m = 1'b0;
        #1 check("fa_e_wb", 32'(forward_a_e), 32'h1);
        rt_e = 5'd3;
        #1 check("fb_e_wb", 32'(forward_b_e), 32'h1);
        rs_e = 5'd0;
        #1 check("fa_e_zero", 32'(forward_a_e), 32'h0);
        clear_inputs();

        // load-use
        @(posedge clk); #1;
        mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd8; rt_d = 5'd8;
        #1 check_stall("lw", 1'b1);
        clear_inputs();
        mem_to_reg_m = 1'b1; reg_write_m = 1'b1; write_reg_m = 5'd8; rt_e = 5'd8;
        #1 check("lw_fb_e_mem", 32'(forward_b_e), 32'h2);
        check_stall("lw_after", 1'b0);
        clear_inputs();

        // branch dependencies
        branch_d = 1'b1; rs_d = 5'd5; reg_write_e = 1'b1; write_reg_e = 5'd5;
        #1 check_stall("br_e", 1'b1);
        check("br_e_fa_d", 32'(forward_a_d), 0);
        reg_write_e = 1'b0; write_reg_e = 5'd0; reg_write_m = 1'b1; write_reg_m = 5'd5;
        #1 check("br_m_fa_d", 32'(forward_a_d), 1);
        check_stall("br_m_alu", 1'b0);
        reg_write_m = 1'b0; write_reg_m = 5'd0;
        mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd5;
        #1 check_stall("br_lw_e", 1'b1);
        mem_to_reg_e = 1'b0; reg_write_e = 1'b0; write_reg_e = 5'd0;
        mem_to_reg_m = 1'b1; reg_write_m = 1'b1; write_reg_m = 5'd5;
        #1 check_stall("br_lw_m", 1'b1);
        check("br_lw_m_fa_d", 32'(forward_a_d), 1);
        mem_to_reg_m = 1'b0; reg_write_m = 1'b0; write_reg_m = 5'd0;
        reg_write_w = 1'b1; write_reg_w = 5'd5;
        #1 check_stall("br_lw_w", 1'b0);
        rs_d = 5'd0; rt_d = 5'd0; reg_write_e = 1'b1; write_reg_e = 5'd0;
        #1 check_stall("br_r0", 1'b0);
        clear_inputs();

        // mult/div busy window
        @(posedge clk); #1;
        md_start_e = 1'b1; md_use_d = 1'b1;
        #1 check_stall("md_start", 1'b1);
        check("md_start_busy", 32'(md_busy), 0);
        @(posedge clk); #1 md_start_e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("md_busy_%0d", i), 32'(md_busy), 1);
            check($sformatf("md_stall_%0d", i), 32'(stall_d), 1);
            @(posedge clk); #1;
        end
        check("md_done_busy", 32'(md_busy), 0);
        check_stall("md_done", 1'b0);

        // reset mid-BUSY
        md_start_e = 1'b1; md_use_d = 1'b0;
        @(posedge clk); #1 md_start_e = 1'b0;
        @(posedge clk); #1;
        check("md_mid_busy", 32'(md_busy), 1);
        rst_n = 1'b0;
        #1 check("md_rst_busy", 32'(md_busy), 0);
        rst_n = 1'b1; md_use_d = 1'b1;
        #1 check_stall("md_rst_use", 1'b0);
        @(posedge clk); #1;
        check("md_rst_busy_after", 32'(md_busy), 0);
        check_stall("md_rst_use_after", 1'b0);
        clear_inputs();

        // perf counter saturation
        rst_n = 1'b0;
        #1 check("perf_rst", 32'(perf_stall_cnt), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_to_reg_e = 1'b1; write_reg_e = 5'd8; rt_d = 5'd8;
        repeat (5) @(posedge clk);
        #1 check("perf_stall_5", 32'(perf_stall_cnt), 32'(PERF_5));
        repeat (15) @(posedge clk);
        #1 check("perf_stall_sat", 32'(perf_stall_cnt), 32'(PERF_SAT));
        check("perf_fwd_none", 32'(perf_fwd_cnt), 0);
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
